// File: rtl/dmem_pkg.sv
// Shared types for the wait-state data memory.
//   state_t     : handshake FSM states (IDLE/BUSY/DONE)
//   CNT_W/cnt_t : wait counter width and type (LATENCY range 0..15)
//   err_cause_t : reason an access was rejected, used by checks and assertions
//   classify()  : derives the error cause from a request's address and op bits
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE,
    ERR_CONFLICT
  } err_cause_t;

  // aw is log2(DEPTH); any set bit at or above word-index bit aw is out of range.
  function automatic err_cause_t classify(input logic [31:0] addr,
                                          input logic        rd,
                                          input logic        wr,
                                          input int unsigned aw);
    if (rd && wr)                    return ERR_CONFLICT;
    if (addr[1:0] != 2'b00)          return ERR_MISALIGN;
    if ((addr >> (aw + 2)) != '0)    return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte synchronous write and a registered read.
//   clk_i    : clock
//   rst_i    : async active-high reset (read register only; storage is not reset)
//   idx_i    : word index
//   wdata_i  : write data
//   wr_be_i  : per-byte write strobes (all zero = no write)
//   rd_en_i  : load the read register this edge
//   rd_clr_i : with rd_en_i, load zero instead of the stored word
//   rdata_o  : registered read data
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(DEPTH)-1:0]   idx_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wr_be_i,
  input  logic                       rd_en_i,
  input  logic                       rd_clr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < DATA_W / 8; k++) begin
      if (wr_be_i[k]) mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rdata_o <= '0;
    else if (rd_en_i) rdata_o <= rd_clr_i ? '0 : mem[idx_i];
  end

endmodule

// File: rtl/data_memory_ws.sv
// Single-port data memory with request/ready handshake and LATENCY wait states.
//   clk_i, rst_i          : clock, async active-high reset
//   addr_i                : byte address
//   data_i, be_i          : write data and byte enables
//   MemRead_i, MemWrite_i : request strobes, held by the requester until ready_o
//   data_o                : read data (zero after an errored access)
//   ready_o               : one-cycle completion pulse (DONE state)
//   stall_o               : combinational stall to the hazard unit
//   err_o                 : error flag of the completing access
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic                  err_o
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned AW   = $clog2(DEPTH);

  state_t state_q, state_d;
  cnt_t   cnt_q;

  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_q, wr_q, err_q;

  logic              req;
  logic [31:0]       addr_e;
  logic [DATA_W-1:0] data_e;
  logic [BE_W-1:0]   be_e;
  logic              rd_e, wr_e, err_e, finishing;
  err_cause_t        cause;
  logic [BE_W-1:0]   wr_be;

  assign req = MemRead_i | MemWrite_i;

  // With LATENCY=0 the access completes on the capture edge itself, so the
  // live inputs stand in for the captured copy while still in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      addr_e = addr_i;
      data_e = data_i;
      be_e   = be_i;
      rd_e   = MemRead_i;
      wr_e   = MemWrite_i;
    end else begin
      addr_e = addr_q;
      data_e = data_q;
      be_e   = be_q;
      rd_e   = rd_q;
      wr_e   = wr_q;
    end
  end

  assign cause = classify(addr_e, rd_e, wr_e, AW);
  assign err_e = (cause != ERR_NONE);

  // True on the edge that enters DONE.
  assign finishing = ((state_q == IDLE) && req && (LATENCY == 0)) ||
                     ((state_q == BUSY) && (cnt_q == cnt_t'(1)));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = (LATENCY == 0) ? DONE : BUSY;
      BUSY: if (cnt_q == cnt_t'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o = (state_q == DONE);
  end

  assign stall_o = req & ~ready_o;
  assign err_o   = err_q;

  // Request capture, wait counter and error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q <= addr_i;
        data_q <= data_i;
        be_q   <= be_i;
        rd_q   <= MemRead_i;
        wr_q   <= MemWrite_i;
        cnt_q  <= cnt_t'(LATENCY);
      end else if (state_q == BUSY) begin
        cnt_q  <= cnt_q - cnt_t'(1);
      end
      if (finishing)              err_q <= err_e;
      else if (state_q == DONE)   err_q <= 1'b0;
    end
  end

  assign wr_be = (finishing && wr_e && !err_e) ? be_e : '0;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx_i    (addr_e[AW+1:2]),
    .wdata_i  (data_e),
    .wr_be_i  (wr_be),
    .rd_en_i  (finishing && (rd_e || err_e)),
    .rd_clr_i (err_e),
    .rdata_o  (data_o)
  );

  ready_pulse_a: assert property (@(posedge clk_i) disable iff (rst_i) ready_o |=> !ready_o);
  err_in_done_a: assert property (@(posedge clk_i) disable iff (rst_i) err_o |-> ready_o);

endmodule

// File: tb/tb_data_memory_ws.sv
module tb_data_memory_ws;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: LATENCY=2, instance b: LATENCY=0
  logic [31:0] addr_a, wdat_a, rdat_a, addr_b, wdat_b, rdat_b;
  logic [3:0]  be_a, be_b;
  logic        rd_a, wr_a, rdy_a, stl_a, err_a;
  logic        rd_b, wr_b, rdy_b, stl_b, err_b;

  int checks = 0;
  int errors = 0;

  data_memory_ws #(.DATA_W(32), .DEPTH(64), .LATENCY(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .addr_i(addr_a), .data_i(wdat_a), .be_i(be_a),
    .MemRead_i(rd_a), .MemWrite_i(wr_a), .data_o(rdat_a), .ready_o(rdy_a),
    .stall_o(stl_a), .err_o(err_a)
  );

  data_memory_ws #(.DATA_W(32), .DEPTH(64), .LATENCY(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .addr_i(addr_b), .data_i(wdat_b), .be_i(be_b),
    .MemRead_i(rd_b), .MemWrite_i(wr_b), .data_o(rdat_b), .ready_o(rdy_b),
    .stall_o(stl_b), .err_o(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if (s == 0) begin
      rd_a = r; wr_a = w; addr_a = a; wdat_a = d; be_a = b;
    end else begin
      rd_b = r; wr_b = w; addr_b = a; wdat_b = d; be_b = b;
    end
  endtask

  function automatic logic rdy_of(input int s);
    return (s == 0) ? rdy_a : rdy_b;
  endfunction
  function automatic logic stl_of(input int s);
    return (s == 0) ? stl_a : stl_b;
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE. Returns cycles to
  // ready, stall cycles seen, and outputs sampled in the DONE cycle.
  task automatic access(input int s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        output int lat, output int stalls,
                        output logic [31:0] dq, output logic eq, output logic sd);
    drive(s, r, w, a, d, b);
    lat = 0;
    stalls = 0;
    #1;
    while (!rdy_of(s) && lat < 40) begin
      if (stl_of(s)) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    dq = (s == 0) ? rdat_a : rdat_b;
    eq = (s == 0) ? err_a : err_b;
    sd = stl_of(s);
    drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
  endtask

  int          lat, stalls;
  logic [31:0] dq;
  logic        eq, sd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", rdy_a, 0);
    check("reset_err",   err_a, 0);
    check("reset_data",  rdat_a, 32'h0);
    check("reset_stall", stl_a, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic write/read, LATENCY=2
    access(0, 0, 1, 32'h8, 32'hDEADBEEF, 4'hF, lat, stalls, dq, eq, sd);
    check("wr_latency", lat, 3);
    check("wr_stalls", stalls, 3);
    check("wr_err", eq, 0);
    check("wr_stall_done", sd, 0);
    access(0, 1, 0, 32'h8, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("rd_latency", lat, 3);
    check("rd_stalls", stalls, 3);
    check("rd_data", dq, 32'hDEADBEEF);
    check("rd_err", eq, 0);

    // Byte enables
    access(0, 0, 1, 32'h18, 32'h11223344, 4'hF, lat, stalls, dq, eq, sd);
    access(0, 0, 1, 32'h18, 32'hAABBCCDD, 4'b0101, lat, stalls, dq, eq, sd);
    check("wr_keeps_data_o", dq, 32'hDEADBEEF);
    access(0, 1, 0, 32'h18, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("be_merge", dq, 32'h11BB33DD);

    // be=0 write is a legal no-op
    access(0, 0, 1, 32'h8, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("be0_err", eq, 0);
    access(0, 1, 0, 32'h8, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("be0_unchanged", dq, 32'hDEADBEEF);

    // Misaligned read
    access(0, 1, 0, 32'h6, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("misalign_err", eq, 1);
    check("misalign_data", dq, 32'h0);

    // Out-of-range write aliases word 0 in the index bits; must not write it
    access(0, 0, 1, 32'h0, 32'hA5A5A5A5, 4'hF, lat, stalls, dq, eq, sd);
    access(0, 1, 0, 32'h0, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("word0_data", dq, 32'hA5A5A5A5);
    access(0, 0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, lat, stalls, dq, eq, sd);
    check("range_err", eq, 1);
    check("range_data", dq, 32'h0);
    access(0, 1, 0, 32'h0, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("range_mem_unchanged", dq, 32'hA5A5A5A5);

    // Read and write both high
    access(0, 1, 1, 32'h8, 32'h0, 4'hF, lat, stalls, dq, eq, sd);
    check("conflict_err", eq, 1);
    check("conflict_data", dq, 32'h0);
    access(0, 1, 0, 32'h8, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("conflict_mem_unchanged", dq, 32'hDEADBEEF);

    // Reset during BUSY of a write
    access(0, 0, 1, 32'hC, 32'h5, 4'hF, lat, stalls, dq, eq, sd);
    access(0, 1, 0, 32'hC, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("pre_reset_data", dq, 32'h5);
    drive(0, 1'b0, 1'b1, 32'hC, 32'h99, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", rdy_a, 0);
    check("midrst_err", err_a, 0);
    check("midrst_data", rdat_a, 32'h0);
    check("midrst_state", dut_a.state_q, IDLE);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    access(0, 1, 0, 32'hC, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("midrst_mem_kept", dq, 32'h5);

    // Inputs changed after capture are ignored
    access(0, 0, 1, 32'h14, 32'h12345678, 4'hF, lat, stalls, dq, eq, sd);
    drive(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
    lat = 1;
    while (!rdy_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("capture_latency", lat, 3);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("capture_target", dq, 32'hCAFEF00D);
    access(0, 1, 0, 32'h14, 32'h0, 4'h0, lat, stalls, dq, eq, sd);
    check("capture_other_untouched", dq, 32'h12345678);

    // LATENCY=0 instance
    access(1, 0, 1, 32'h0, 32'h01020304, 4'hF, lat, stalls, dq, eq, sd);
    check("l0_wr_latency", lat, 1);
    check("l0_wr_stalls", stalls, 1);
    access(1, 0, 1, 32'h4, 32'h05060708, 4'hF, lat, stalls, dq, eq, sd);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("l0_b2b_T_stall", stl_b, 1);
    check("l0_b2b_T_ready", rdy_b, 0);
    @(posedge clk); #1;
    check("l0_b2b_T1_ready", rdy_b, 1);
    check("l0_b2b_T1_data", rdat_b, 32'h01020304);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    #1;
    check("l0_b2b_T1_stall", stl_b, 0);
    @(posedge clk); #1;
    check("l0_b2b_gap_ready", rdy_b, 0);
    check("l0_b2b_gap_stall", stl_b, 1);
    @(posedge clk); #1;
    check("l0_b2b_T3_ready", rdy_b, 1);
    check("l0_b2b_T3_data", rdat_b, 32'h05060708);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("l0_idle_ready", rdy_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
# data_memory_ws

Parametrised single-port data memory for the pipelined CPU's MEM stage, replacing the zero-latency combinational memory. Adds a clocked request/ready handshake with a configurable wait-state count, byte-enable writes for sb/sh, and error flagging for misaligned, out-of-range or conflicting accesses. Drives a combinational stall to the hazard unit while an access is outstanding.

## Interface
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 64, number of words; power of two, at least 2.
- LATENCY, 2, wait cycles per access; 0..15.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- addr_i  in  32  byte address.
- data_i  in  DATA_W  write data.
- be_i  in  DATA_W/8  byte enables for writes; bit k selects data_i[8k+7:8k].
- MemRead_i  in  1  read request.
- MemWrite_i  in  1  write request.
- data_o  out  DATA_W  read data; reset 0.
- ready_o  out  1  one-cycle completion pulse; reset 0.
- stall_o  out  1  combinational: (MemRead_i | MemWrite_i) & ~ready_o.
- err_o  out  1  error status of the completing access; reset 0.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE: when MemRead_i | MemWrite_i is high, capture addr_i, data_i, be_i, and the op. Load the wait counter with LATENCY. Go to BUSY if LATENCY > 0, else go to DONE.
- BUSY: decrement the counter each cycle. Go to DONE on the edge where the counter is 1.
- DONE: ready_o = 1 and err_o is valid, for exactly one cycle. Request inputs are ignored. Always go to IDLE.
- Word index = captured addr[log2(DEPTH)+1:2].
- Error conditions, evaluated on captured values:
  - addr[1:0] != 0 (misaligned);
  - addr >> 2 >= DEPTH (out of range);
  - MemRead and MemWrite both high.
- An errored access performs no write, and data_o is set to 0.
- Write: on the edge entering DONE, update only the bytes whose be_i bit is set. be_i = 0 is a legal no-op with no error.
- Read: on the edge entering DONE, data_o is loaded with the full word; be_i is ignored. data_o holds until the next completing read or errored access. Writes leave data_o unchanged.
- The memory array is not reset. Contents are undefined until written.

## Timing
- Request seen in IDLE at cycle T. ready_o is high in cycle T+LATENCY+1.
- Throughput: one access per LATENCY+2 cycles.
- stall_o is high from cycle T through T+LATENCY and low in the DONE cycle, which lets the pipeline advance.
- The requester holds its request until ready_o. Changes to the inputs after capture have no effect on the access in flight.
- Read-after-write to the same word returns the new data once the write's DONE cycle has passed.
- Reset asserted mid-access:
  - immediately returns to IDLE;
  - discards the pending write (the memory is untouched);
  - clears ready_o, err_o and data_o.

## Structure
- Package dmem_pkg: state enum (IDLE/BUSY/DONE), wait counter width (4 bits), and an error-cause encoding for assertions.
- Sub-module dmem_array: DEPTH x DATA_W storage with synchronous per-byte write and a read port registered on the same enable. The FSM, counter, error checks and handshake stay in data_memory_ws.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x8 (be=4'hF), then read 0x8 -> ready_o in cycle T+3, data_o=0xDEADBEEF, stall_o high for 3 cycles per access.
- Byte enables: write 0x11223344 (be=F), then write 0xAABBCCDD with be=4'b0101 to the same word -> a read returns 0x11BB33DD.
- Errors: read 0x6 -> err_o=1 and data_o=0. Write 0x100 with DEPTH=64 -> err_o=1 and the memory is unchanged. Both MemRead and MemWrite high -> err_o=1.
- LATENCY=0: back-to-back reads of 0x0 and 0x4 -> ready_o in cycles T+1 and T+3, with a gap cycle between.
- Reset during BUSY of a write to 0xC (old value 0x5) -> outputs are 0 and the FSM is IDLE; a later read of 0xC returns 0x5.
- Changing addr_i and data_i during BUSY -> the captured values are used; the completing access matches the originally requested address and data.
